mcoi_led_sequencer: RTL and testbench



---
 rtl/mcoi_led_sequencer_pkg.sv | 22 ++
 rtl/mcoi_led_sequencer_channel.sv | 117 +++++++++++
 rtl/mcoi_led_sequencer.sv | 60 ++++++
 tb/tb_mcoi_led_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcoi_led_sequencer_pkg.sv
// Shared types and default timing for the MCOI diagnostic LED sequencer.
// Defaults give a 1 kHz tick at 100 MHz and 250 ms blink phases.
package McoiLedPkg;

  typedef enum logic [1:0] {LED_OFF, LED_ON, LED_BLINK, LED_BURST} led_mode_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ON_PH, ST_OFF_PH, ST_GAP} led_state_t;

  localparam int NUM_LEDS_DEF   = 6;
  localparam int PRESC_DIV_DEF  = 100000;
  localparam int HALF_TICKS_DEF = 250;
  localparam int GAP_TICKS_DEF  = 1000;
  localparam int CNT_W_DEF      = 4;

  // Phase counter only ever holds limit-1 of the longer of the two phase kinds.
  function automatic int phase_width(input int half_ticks, input int gap_ticks);
    int longest;
    longest = (half_ticks > gap_ticks) ? half_ticks : gap_ticks;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/mcoi_led_sequencer_channel.sv
// One LED channel: mode latch, phase/flash counters and the FSM that drives
// the (polarity-free) registered LED bit.
module mcoi_led_channel
  import McoiLedPkg::*;
#(
  parameter int HALF_TICKS = HALF_TICKS_DEF,
  parameter int GAP_TICKS  = GAP_TICKS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  led_mode_t        mode,
  input  logic [CNT_W-1:0] count,
  output logic             led
);

  localparam int PH_W = phase_width(HALF_TICKS, GAP_TICKS);
  localparam logic [PH_W-1:0] HALF_END = PH_W'(HALF_TICKS - 1);
  localparam logic [PH_W-1:0] GAP_END  = PH_W'(GAP_TICKS - 1);

  led_mode_t        mode_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] flashes;
  led_state_t       state;
  logic [PH_W-1:0]  phase;

  // The LED bit is registered together with the state it belongs to, so a
  // load is visible on the pin one cycle later; a load masks a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= LED_OFF;
      count_q <= '0;
      flashes <= '0;
      state   <= ST_IDLE;
      phase   <= '0;
      led     <= 1'b0;
    end else if (load) begin
      mode_q  <= mode;
      count_q <= count;
      phase   <= '0;
      case (mode)
        LED_ON: begin
          state <= ST_IDLE;
          led   <= 1'b1;
        end
        LED_BLINK: begin
          state <= ST_ON_PH;
          led   <= 1'b1;
        end
        LED_BURST: begin
          flashes <= count;
          if (count != '0) begin
            state <= ST_ON_PH;
            led   <= 1'b1;
          end else begin
            state <= ST_GAP;
            led   <= 1'b0;
          end
        end
        default: begin
          mode_q <= LED_OFF;
          state  <= ST_IDLE;
          led    <= 1'b0;
        end
      endcase
    end else if (tick) begin
      case (state)
        ST_ON_PH: begin
          if (phase == HALF_END) begin
            phase <= '0;
            state <= ST_OFF_PH;
            led   <= 1'b0;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        ST_OFF_PH: begin
          if (phase == HALF_END) begin
            phase <= '0;
            if (mode_q != LED_BURST) begin
              state <= ST_ON_PH;
              led   <= 1'b1;
            end else if (flashes > CNT_W'(1)) begin
              flashes <= flashes - CNT_W'(1);
              state   <= ST_ON_PH;
              led     <= 1'b1;
            end else begin
              flashes <= '0;
              state   <= ST_GAP;
            end
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        ST_GAP: begin
          if (phase == GAP_END) begin
            phase <= '0;
            // A zero-length code just keeps re-entering the gap.
            if (count_q != '0) begin
              flashes <= count_q;
              state   <= ST_ON_PH;
              led     <= 1'b1;
            end
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        default: begin
          phase <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mcoi_led_sequencer.sv
// Multi-channel diagnostic LED driver: one free-running prescaler shared by
// NUM_LEDS independent OFF/ON/BLINK/BURST channel engines.
module mcoi_led_sequencer
  import McoiLedPkg::*;
#(
  parameter int NUM_LEDS   = NUM_LEDS_DEF,
  parameter int PRESC_DIV  = PRESC_DIV_DEF,
  parameter int HALF_TICKS = HALF_TICKS_DEF,
  parameter int GAP_TICKS  = GAP_TICKS_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  led_mode_t [NUM_LEDS-1:0]        mode_i,
  input  logic [NUM_LEDS-1:0][CNT_W-1:0]  count_i,
  input  logic [NUM_LEDS-1:0]             load_i,
  output logic [NUM_LEDS-1:0]             led_o,
  output logic                            tick_o
);

  localparam int PR_W = $clog2(PRESC_DIV);
  localparam logic [PR_W-1:0] PR_END = PR_W'(PRESC_DIV - 1);

  logic [PR_W-1:0]     presc;
  logic [NUM_LEDS-1:0] led_raw;

  // Free-running: loads never restart it, so channels share one tick grid.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (presc == PR_END) begin
      presc <= '0;
    end else begin
      presc <= presc + PR_W'(1);
    end
  end

  assign tick_o = (presc == PR_END);

  for (genvar k = 0; k < NUM_LEDS; k++) begin : g_chan
    mcoi_led_channel #(
      .HALF_TICKS (HALF_TICKS),
      .GAP_TICKS  (GAP_TICKS),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick_o),
      .load  (load_i[k]),
      .mode  (mode_i[k]),
      .count (count_i[k]),
      .led   (led_raw[k])
    );
  end

  // Channel LED bits are already registered; only the pin polarity is applied here.
  assign led_o = led_raw ^ {NUM_LEDS{ACTIVE_LOW}};

endmodule

// File: tb/tb_mcoi_led_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expected led_o/tick_o derived
// from hand-computed pattern formulas; a negedge monitor pops and compares.
module tb_mcoi_led_sequencer;
  import McoiLedPkg::*;

  localparam int NUM_LEDS   = 3;
  localparam int PRESC_DIV  = 4;
  localparam int HALF_TICKS = 2;
  localparam int GAP_TICKS  = 3;
  localparam int CNT_W      = 4;
  localparam bit ACTIVE_LOW = 1'b0;

  localparam int HALF_CLK = PRESC_DIV * HALF_TICKS;
  localparam int GAP_CLK  = PRESC_DIV * GAP_TICKS;

  localparam int K_OFF   = 0;
  localparam int K_ON    = 1;
  localparam int K_BLINK = 2;
  localparam int K_BURST = 3;

  typedef struct {
    int                  cyc;
    logic [NUM_LEDS-1:0] led;
    logic                tick;
    string               tag;
  } exp_t;

  logic                           clk;
  logic                           rst;
  led_mode_t [NUM_LEDS-1:0]       mode_i;
  logic [NUM_LEDS-1:0][CNT_W-1:0] count_i;
  logic [NUM_LEDS-1:0]            load_i;
  logic [NUM_LEDS-1:0]            led_o;
  logic                           tick_o;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               cyc = 0;
  int               rel_cyc = 0;
  int               tests_run = 0;
  int               tests_failed = 0;
  string            tag = "reset";
  int               kind[NUM_LEDS];
  int               start[NUM_LEDS];
  int               flashes[NUM_LEDS];
  led_mode_t        stage_mode[NUM_LEDS];
  logic [CNT_W-1:0] stage_count[NUM_LEDS];

  mcoi_led_sequencer #(
    .NUM_LEDS   (NUM_LEDS),
    .PRESC_DIV  (PRESC_DIV),
    .HALF_TICKS (HALF_TICKS),
    .GAP_TICKS  (GAP_TICKS),
    .CNT_W      (CNT_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mode_i  (mode_i),
    .count_i (count_i),
    .load_i  (load_i),
    .led_o   (led_o),
    .tick_o  (tick_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic tick_exp(input int c);
    return (c > rel_cyc) && (((c - rel_cyc) % PRESC_DIV) == PRESC_DIV - 1);
  endfunction

  function automatic logic led_exp(input int k, input int c);
    int t;
    int per;
    int p;
    t = c - start[k];
    case (kind[k])
      K_ON:    return 1'b1;
      K_BLINK: return ((t / HALF_CLK) % 2) == 0;
      K_BURST: begin
        per = 2 * HALF_CLK * flashes[k] + GAP_CLK;
        p   = t % per;
        return (p < 2 * HALF_CLK * flashes[k]) && ((p % (2 * HALF_CLK)) < HALF_CLK);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic stage(input int k, input led_mode_t m, input logic [CNT_W-1:0] n);
    stage_mode[k]  = m;
    stage_count[k] = n;
  endtask

  // Drive one cycle's inputs and queue the outputs expected in the next cycle.
  task automatic drive_cycle(input logic rst_v, input logic [NUM_LEDS-1:0] load_v);
    exp_t e;
    rst    = rst_v;
    load_i = load_v;
    for (int k = 0; k < NUM_LEDS; k++) begin
      mode_i[k]  = stage_mode[k];
      count_i[k] = stage_count[k];
    end
    if (rst_v) begin
      for (int k = 0; k < NUM_LEDS; k++) kind[k] = K_OFF;
      rel_cyc = cyc + 1;
    end else begin
      for (int k = 0; k < NUM_LEDS; k++) begin
        if (load_v[k]) begin
          start[k] = cyc + 1;
          case (stage_mode[k])
            LED_ON:    kind[k] = K_ON;
            LED_BLINK: kind[k] = K_BLINK;
            LED_BURST: begin
              flashes[k] = int'(stage_count[k]);
              kind[k]    = (stage_count[k] != '0) ? K_BURST : K_OFF;
            end
            default:   kind[k] = K_OFF;
          endcase
        end
      end
    end
    e.cyc = cyc + 1;
    for (int k = 0; k < NUM_LEDS; k++) e.led[k] = led_exp(k, cyc + 1) ^ ACTIVE_LOW;
    e.tick = rst_v ? 1'b0 : tick_exp(cyc + 1);
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic rst_v, input logic [NUM_LEDS-1:0] load_v,
                               input bit align);
    @(negedge clk);
    if (align) begin
      for (int i = 0; i < PRESC_DIV && !tick_exp(cyc); i++) begin
        drive_cycle(1'b0, '0);
        @(negedge clk);
      end
    end
    drive_cycle(rst_v, load_v);
  endtask

  task automatic checkOutput(input exp_t e);
    tests_run += 2;
    if (led_o !== e.led) begin
      tests_failed++;
      $display("[TB] FAIL led_o %s cyc=%0d got=%b want=%b", e.tag, e.cyc, led_o, e.led);
    end
    if (tick_o !== e.tick) begin
      tests_failed++;
      $display("[TB] FAIL tick_o %s cyc=%0d got=%b want=%b", e.tag, e.cyc, tick_o, e.tick);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.cyc == cyc) begin
        checkOutput(mon_e);
      end else begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL stale %s cyc=%0d got=missed want=checked", mon_e.tag, mon_e.cyc);
      end
    end
  end

  initial begin
    for (int k = 0; k < NUM_LEDS; k++) begin
      stage(k, LED_OFF, '0);
      kind[k]    = K_OFF;
      start[k]   = 0;
      flashes[k] = 0;
    end
    drive_cycle(1'b1, '0);
    repeat (4) applyStimulus(1'b1, '0, 1'b0);

    tag = "prescaler";
    repeat (8) applyStimulus(1'b0, '0, 1'b0);

    tag = "on_blink";
    stage(0, LED_ON, '0);
    stage(1, LED_BLINK, '0);
    applyStimulus(1'b0, 3'b011, 1'b1);
    repeat (48) applyStimulus(1'b0, '0, 1'b0);

    tag = "burst2";
    stage(2, LED_BURST, 4'd2);
    applyStimulus(1'b0, 3'b100, 1'b1);
    repeat (3 * 44) applyStimulus(1'b0, '0, 1'b0);

    // Land the OFF load on a tick three cycles into a BLINK ON phase.
    tag = "off_on_tick";
    stage(1, LED_OFF, '0);
    for (int i = 0; i < 64; i++) begin
      if (tick_exp(cyc + 1) && ((cyc + 1 - start[1]) % (2 * HALF_CLK)) == 3) break;
      applyStimulus(1'b0, '0, 1'b0);
    end
    applyStimulus(1'b0, 3'b010, 1'b0);
    repeat (20) applyStimulus(1'b0, '0, 1'b0);

    tag = "burst0";
    stage(2, LED_BURST, 4'd0);
    applyStimulus(1'b0, 3'b100, 1'b0);
    repeat (200) applyStimulus(1'b0, '0, 1'b0);
    tag = "burst0_on";
    stage(2, LED_ON, '0);
    applyStimulus(1'b0, 3'b100, 1'b0);
    repeat (5) applyStimulus(1'b0, '0, 1'b0);

    tag = "reset_mid";
    stage(2, LED_BURST, 4'd2);
    applyStimulus(1'b0, 3'b100, 1'b1);
    repeat (3) applyStimulus(1'b0, '0, 1'b0);
    repeat (2) applyStimulus(1'b1, '0, 1'b0);
    tag = "after_reset";
    repeat (20) applyStimulus(1'b0, '0, 1'b0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain got=%0d want=0 pending", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
